// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with load/add/sub/adc, registered global status flags
// and optional signed saturation. Out-of-range selects read as zero and ignore writes.
module acc_bank #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_ACC = 4,
    parameter bit          SAT     = 1'b0,
    parameter int unsigned SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWrite,
    input  logic [1:0]       op,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_ADC  = 2'b11
    } op_t;

    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc [NUM_ACC];
    logic [WIDTH-1:0] a;
    logic             hit;
    op_t              op_e;
    logic [WIDTH:0]   raw;
    logic             raw_c;
    logic             raw_v;
    logic [WIDTH-1:0] res;

    assign op_e = op_t'(op);

    // Decoded mux rather than acc[sel]: selects past NUM_ACC fall through to zero.
    always_comb begin
        a   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_ACC; i++) begin
            if (sel == SEL_W'(i)) begin
                a   = acc[i];
                hit = 1'b1;
            end
        end
    end

    assign out = a;

    always_comb begin
        raw   = '0;
        raw_c = 1'b0;
        raw_v = 1'b0;
        case (op_e)
            OP_LOAD: begin
                raw = {1'b0, in};
            end
            OP_ADD: begin
                raw   = {1'b0, a} + {1'b0, in};
                raw_c = raw[WIDTH];
                raw_v = (a[MSB] == in[MSB]) && (raw[MSB] != a[MSB]);
            end
            OP_SUB: begin
                raw   = {1'b0, a} - {1'b0, in};
                raw_c = raw[WIDTH];
                raw_v = (a[MSB] != in[MSB]) && (raw[MSB] != a[MSB]);
            end
            OP_ADC: begin
                raw   = {1'b0, a} + {1'b0, in} + {{WIDTH{1'b0}}, carry};
                raw_c = raw[WIDTH];
                raw_v = (a[MSB] == in[MSB]) && (raw[MSB] != a[MSB]);
            end
            default: begin
                raw = '0;
            end
        endcase

        // Overflow direction always follows the sign of the accumulator operand.
        res = raw[WIDTH-1:0];
        if (SAT && raw_v) begin
            res = a[MSB] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
            end
            zero  <= 1'b0;
            neg   <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (regWrite && hit) begin
            for (int unsigned i = 0; i < NUM_ACC; i++) begin
                if (sel == SEL_W'(i)) begin
                    acc[i] <= res;
                end
            end
            zero  <= (res == '0);
            neg   <= res[MSB];
            carry <= raw_c;
            ovf   <= raw_v;
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank: three instances (wrap, saturating, NUM_ACC=3) share
// stimulus; an integer reference model pushes expectations that are popped after each edge.
module tb_acc_bank;

    logic       clk;
    logic       rst;
    logic       regWrite;
    logic [1:0] op;
    logic [1:0] sel;
    logic [7:0] din;
    logic [7:0] o [3];
    logic       z [3];
    logic       n [3];
    logic       c [3];
    logic       v [3];

    int compared   = 0;
    int mismatched = 0;

    acc_bank #(.WIDTH(8), .NUM_ACC(4), .SAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .regWrite(regWrite), .op(op), .sel(sel), .in(din),
        .out(o[0]), .zero(z[0]), .neg(n[0]), .carry(c[0]), .ovf(v[0])
    );
    acc_bank #(.WIDTH(8), .NUM_ACC(4), .SAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .regWrite(regWrite), .op(op), .sel(sel), .in(din),
        .out(o[1]), .zero(z[1]), .neg(n[1]), .carry(c[1]), .ovf(v[1])
    );
    acc_bank #(.WIDTH(8), .NUM_ACC(3), .SAT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .regWrite(regWrite), .op(op), .sel(sel), .in(din),
        .out(o[2]), .zero(z[2]), .neg(n[2]), .carry(c[2]), .ovf(v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [11:0] exp;
        string       tag;
    } sb_t;

    typedef struct {
        bit         r;
        bit         we;
        logic [1:0] op;
        logic [1:0] sel;
        logic [7:0] d;
    } row_t;

    sb_t sb[$];

    int nacc [3] = '{4, 4, 3};
    bit sat  [3] = '{1'b0, 1'b1, 1'b0};
    int m_acc [3][4];
    bit m_z [3];
    bit m_n [3];
    bit m_c [3];
    bit m_v [3];

    function automatic row_t mk(bit r, bit we, logic [1:0] opv, logic [1:0] s, logic [7:0] d);
        row_t t;
        t.r = r; t.we = we; t.op = opv; t.sel = s; t.d = d;
        return t;
    endfunction

    // Signed/unsigned integer arithmetic, independent of the bit-level RTL formulation.
    task automatic model(int k, row_t s);
        int a, b, sa, sbv, u, sr, st;
        bit cy, ov;
        if (s.r) begin
            for (int j = 0; j < 4; j++) m_acc[k][j] = 0;
            m_z[k] = 0; m_n[k] = 0; m_c[k] = 0; m_v[k] = 0;
        end else if (s.we && int'(s.sel) < nacc[k]) begin
            a   = m_acc[k][s.sel];
            b   = int'(s.d);
            sa  = (a > 127) ? a - 256 : a;
            sbv = (b > 127) ? b - 256 : b;
            u = 0; sr = 0; cy = 0;
            case (s.op)
                2'd0: begin u = b; sr = 0; cy = 0; end
                2'd1: begin u = a + b; cy = (u > 255); sr = sa + sbv; end
                2'd2: begin u = a - b + 256; cy = (a < b); sr = sa - sbv; end
                default: begin
                    u = a + b + int'(m_c[k]); cy = (u > 255); sr = sa + sbv + int'(m_c[k]);
                end
            endcase
            ov = (s.op != 2'd0) && (sr > 127 || sr < -128);
            if (ov && sat[k]) st = (sr > 127) ? 127 : 128;
            else              st = u % 256;
            m_acc[k][s.sel] = st;
            m_z[k] = (st == 0);
            m_n[k] = (st >= 128);
            m_c[k] = cy;
            m_v[k] = ov;
        end
    endtask

    task automatic run_row(row_t s, string tag);
        sb_t        e;
        logic [7:0] ev;
        @(negedge clk);
        rst = s.r; regWrite = s.we; op = s.op; sel = s.sel; din = s.d;
        for (int k = 0; k < 3; k++) begin
            model(k, s);
            ev    = (int'(s.sel) < nacc[k]) ? 8'(m_acc[k][s.sel]) : 8'h00;
            e.k   = k;
            e.exp = {ev, m_z[k], m_n[k], m_c[k], m_v[k]};
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        rows.push_back(mk(1, 0, 2'd0, 2'd0, 8'h00));
        for (int i = 0; i < 4; i++) rows.push_back(mk(0, 0, 2'd0, 2'(i), 8'h00));
        rows.push_back(mk(0, 1, 2'd0, 2'd1, 8'hAA));
        for (int i = 0; i < 4; i++) rows.push_back(mk(0, 0, 2'd0, 2'(i), 8'h00));
        rows.push_back(mk(0, 0, 2'd0, 2'd1, 8'h00));
        foreach (rows[r]) begin
            run_row(rows[r], "reset_load");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
        end
        compared++;
        if ({o[0], z[0], n[0]} !== {8'hAA, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL load_aa_const: got out=%h z=%b n=%b required out=aa z=0 n=1", o[0], z[0], n[0]);
        end
    endtask

    task automatic test_hold();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        for (int i = 0; i < 4; i++) rows.push_back(mk(0, 0, 2'd0, 2'(i), 8'h81));
        rows.push_back(mk(0, 0, 2'd0, 2'd1, 8'h81));
        foreach (rows[r]) begin
            run_row(rows[r], "hold");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
        end
        compared++;
        if (o[0] !== 8'hAA) begin
            mismatched++;
            $display("FAIL hold_const: got out=%h required aa", o[0]);
        end
    endtask

    task automatic test_add_adc();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        rows.push_back(mk(0, 1, 2'd0, 2'd0, 8'hFF));
        rows.push_back(mk(0, 1, 2'd1, 2'd0, 8'h01));
        rows.push_back(mk(0, 1, 2'd3, 2'd0, 8'h00));
        foreach (rows[r]) begin
            run_row(rows[r], "add_adc");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
        end
        compared++;
        if ({o[0], c[0]} !== {8'h01, 1'b0}) begin
            mismatched++;
            $display("FAIL adc_const: got out=%h c=%b required out=01 c=0", o[0], c[0]);
        end
    endtask

    task automatic test_sat();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        rows.push_back(mk(0, 1, 2'd0, 2'd2, 8'h7F));
        rows.push_back(mk(0, 1, 2'd1, 2'd2, 8'h01));
        foreach (rows[r]) begin
            run_row(rows[r], "sat_add");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
        end
        compared++;
        if ({o[0], v[0], n[0], o[1], v[1], n[1]} !== {8'h80, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL sat_add_const: got wrap=%h v%b n%b sat=%h v%b n%b required wrap=80 v1 n1 sat=7f v1 n0",
                     o[0], v[0], n[0], o[1], v[1], n[1]);
        end
        rows.delete();
        rows.push_back(mk(0, 1, 2'd0, 2'd2, 8'h80));
        rows.push_back(mk(0, 1, 2'd2, 2'd2, 8'h01));
        foreach (rows[r]) begin
            run_row(rows[r], "sat_sub");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
        end
        compared++;
        if ({o[1], v[1], c[1]} !== {8'h80, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL sat_sub_const: got out=%h v=%b c=%b required out=80 v=1 c=0", o[1], v[1], c[1]);
        end
    endtask

    task automatic test_sub_reset();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        rows.push_back(mk(0, 1, 2'd0, 2'd3, 8'h05));
        rows.push_back(mk(0, 1, 2'd2, 2'd3, 8'h07));
        rows.push_back(mk(1, 1, 2'd0, 2'd3, 8'h55));
        foreach (rows[r]) begin
            run_row(rows[r], "sub_reset");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
            if (r == 1) begin
                compared++;
                if ({o[0], c[0], n[0]} !== {8'hFE, 1'b1, 1'b1}) begin
                    mismatched++;
                    $display("FAIL sub_const: got out=%h c=%b n=%b required out=fe c=1 n=1", o[0], c[0], n[0]);
                end
            end
        end
        compared++;
        if ({o[0], z[0], n[0], c[0], v[0]} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_dominates: got out=%h zncv=%b%b%b%b required out=00 zncv=0000",
                     o[0], z[0], n[0], c[0], v[0]);
        end
    endtask

    task automatic test_oob();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        rows.push_back(mk(0, 1, 2'd0, 2'd2, 8'h3C));
        rows.push_back(mk(0, 1, 2'd0, 2'd3, 8'h99));
        rows.push_back(mk(0, 1, 2'd1, 2'd3, 8'hF0));
        rows.push_back(mk(0, 0, 2'd0, 2'd3, 8'h00));
        rows.push_back(mk(0, 0, 2'd0, 2'd2, 8'h00));
        foreach (rows[r]) begin
            run_row(rows[r], "oob");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
            if (r == 3) begin
                compared++;
                if (o[2] !== 8'h00) begin
                    mismatched++;
                    $display("FAIL oob_read_const: got out=%h required 00", o[2]);
                end
            end
        end
        compared++;
        if ({o[2], z[2], n[2]} !== {8'h3C, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL oob_prior_const: got out=%h z=%b n=%b required out=3c z=0 n=0", o[2], z[2], n[2]);
        end
    endtask

    task automatic test_back_to_back();
        row_t        rows[$];
        sb_t         e;
        logic [11:0] act;
        for (int i = 0; i < 80; i++) begin
            rows.push_back(mk($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                              8'($urandom_range(0, 255))));
        end
        foreach (rows[r]) begin
            run_row(rows[r], "random");
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {o[e.k], z[e.k], n[e.k], c[e.k], v[e.k]};
                compared++;
                if (act !== e.exp) begin
                    mismatched++;
                    $display("FAIL %s dut%0d row%0d: got out=%h zncv=%b required out=%h zncv=%b",
                             e.tag, e.k, r, act[11:4], act[3:0], e.exp[11:4], e.exp[3:0]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; regWrite = 1'b0; op = 2'd0; sel = 2'd0; din = 8'h00;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) m_acc[k][j] = 0;
            m_z[k] = 0; m_n[k] = 0; m_c[k] = 0; m_v[k] = 0;
        end
        repeat (2) @(posedge clk);
        test_reset();
        test_hold();
        test_add_adc();
        test_sat();
        test_sub_reset();
        test_oob();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
